// File: rtl/vga_sync_if.sv
// Sampled VGA sync input and recovered-position output bundle for vga_sync_decoder.
// The master side (a timing generator or capture front end) drives strobe and syncs.
interface vga_sync_if;
  logic        i_pix_stb;
  logic        i_hsync;
  logic        i_vsync;
  logic [15:0] o_x;
  logic [15:0] o_y;
  logic        o_active;
  logic        o_locked;
  logic        o_err;
  logic [7:0]  o_frame_cnt;

  modport master (
    output i_pix_stb, i_hsync, i_vsync,
    input  o_x, o_y, o_active, o_locked, o_err, o_frame_cnt
  );

  modport slave (
    input  i_pix_stb, i_hsync, i_vsync,
    output o_x, o_y, o_active, o_locked, o_err, o_frame_cnt
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers x/y position from sampled active-low Hsync/Vsync and declares lock after good frames.
// Define VGA_SYNC_WIDTH_CHECK_EN to also enforce the Hsync/Vsync pulse widths.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  vga_sync_if.slave bus_if
);

  localparam logic [15:0] H_LOAD = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] V_LOAD = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

  if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15 || H_SYNC == 0 || V_SYNC == 0) begin : g_bad_cfg
    $error("vga_sync_decoder: illegal timing parameters");
  end

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_e;

  state_e      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [15:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic        line_seen_q, line_seen_d;
  logic [3:0]  good_q, good_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        err_q, err_d;

  logic stb, hs_fall, vs_fall, line_err, frame_err, width_err, any_err;

  assign stb     = bus_if.i_pix_stb;
  assign hs_fall = stb & hs_q & ~bus_if.i_hsync;
  assign vs_fall = stb & vs_q & ~bus_if.i_vsync;

  // Frame length counts hsync falls in (previous vsync fall, this vsync fall].
  assign line_err  = hs_fall & line_seen_q & (line_len_q != 16'(H_TOTAL));
  assign frame_err = vs_fall & ((frame_lines_q + 16'(hs_fall)) != 16'(V_TOTAL));

`ifdef VGA_SYNC_WIDTH_CHECK_EN
  logic [15:0] hs_low_q, hs_low_d, vs_low_q, vs_low_d;
  logic        hs_rise, vs_rise;

  assign hs_rise   = stb & ~hs_q & bus_if.i_hsync;
  assign vs_rise   = stb & ~vs_q & bus_if.i_vsync;
  assign width_err = (hs_rise & (hs_low_q != 16'(H_SYNC))) |
                     (vs_rise & (vs_low_q != 16'(V_SYNC)));

  always_comb begin
    hs_low_d = hs_low_q;
    vs_low_d = vs_low_q;
    if (hs_fall) begin
      hs_low_d = 16'd1;
    end else if (stb && !hs_q && !bus_if.i_hsync && hs_low_q != 16'hFFFF) begin
      hs_low_d = hs_low_q + 16'd1;
    end
    if (vs_fall) begin
      vs_low_d = 16'(hs_fall);
    end else if (hs_fall && !vs_q && !bus_if.i_vsync && vs_low_q != 16'hFFFF) begin
      vs_low_d = vs_low_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_low_q <= '0;
      vs_low_q <= '0;
    end else begin
      hs_low_q <= hs_low_d;
      vs_low_q <= vs_low_d;
    end
  end
`else
  assign width_err = 1'b0;
`endif

  assign any_err = line_err | frame_err | width_err;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    hs_d          = hs_q;
    vs_d          = vs_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    line_len_d    = line_len_q;
    line_seen_d   = line_seen_q;
    frame_lines_d = frame_lines_q;
    if (stb) begin
      hs_d = bus_if.i_hsync;
      vs_d = bus_if.i_vsync;
      if (hs_fall)                h_cnt_d = H_LOAD;
      else if (h_cnt_q == H_LAST) h_cnt_d = '0;
      else                        h_cnt_d = h_cnt_q + 16'd1;
      if (vs_fall)                v_cnt_d = V_LOAD;
      else if (hs_fall)           v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 16'd1;
      if (hs_fall) begin
        line_len_d  = 16'd1;
        line_seen_d = 1'b1;
      end else if (line_len_q != 16'hFFFF) begin
        line_len_d = line_len_q + 16'd1;
      end
      if (vs_fall)                                      frame_lines_d = '0;
      else if (hs_fall && frame_lines_q != 16'hFFFF)    frame_lines_d = frame_lines_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;
    unique case (state_q)
      SEARCH: if (vs_fall) begin
        good_d  = '0;
        state_d = CHECK;
      end
      CHECK: if (any_err) begin
        err_d   = 1'b1;
        state_d = SEARCH;
      end else if (vs_fall) begin
        good_d = good_q + 4'd1;
        if (good_q + 4'd1 == 4'(LOCK_FRAMES)) state_d = LOCKED;
      end
      LOCKED: if (any_err) begin
        err_d   = 1'b1;
        state_d = SEARCH;
      end else if (vs_fall) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      default: state_d = SEARCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_len_q    <= '0;
      line_seen_q   <= 1'b0;
      frame_lines_q <= '0;
      good_q        <= '0;
      frame_cnt_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_len_q    <= line_len_d;
      line_seen_q   <= line_seen_d;
      frame_lines_q <= frame_lines_d;
      good_q        <= good_d;
      frame_cnt_q   <= frame_cnt_d;
      err_q         <= err_d;
    end
  end

  assign bus_if.o_x         = h_cnt_q;
  assign bus_if.o_y         = v_cnt_q;
  assign bus_if.o_locked    = (state_q == LOCKED);
  assign bus_if.o_active    = (state_q == LOCKED) && (h_cnt_q < 16'(H_ACTIVE)) &&
                              (v_cnt_q < 16'(V_ACTIVE));
  assign bus_if.o_err       = err_q;
  assign bus_if.o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 24x14 raster; strobe every 4th clk.
// Bench generator advances its line counter on the hsync fall, matching the decoder's y convention.
module tb_vga_sync_decoder;
  localparam int HA = 16, HFP = 2, HS = 4, HT = 24;
  localparam int VA = 8,  VFP = 2, VS = 2, VT = 14;
  localparam int LOCKF = 2;
  localparam int HS_START = HA + HFP;
  localparam int VS_START = VA + VFP;
`ifdef VGA_SYNC_WIDTH_CHECK_EN
  localparam logic W_EN = 1'b1;
`else
  localparam logic W_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_sync_if bus();

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_TOTAL(VT),
    .LOCK_FRAMES(LOCKF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   gx, gy, htot, hsw, vtot;
  int   err_sight;
  int   e0;
  logic gen_vs_fall, gen_hs_rise, err_now, lock_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample_after();
    if (bus.o_err === 1'b1) err_sight++;
    if (bus.o_locked === 1'b1) lock_seen = 1'b1;
  endtask

  // One pixel strobe: advance generator, present syncs with strobe for one clk, idle three.
  task automatic do_strobe();
    logic hs_n, vs_n;
    gx = (gx == htot - 1) ? 0 : gx + 1;
    if (gx == HS_START) gy = (gy == vtot - 1) ? 0 : gy + 1;
    hs_n = !(gx >= HS_START && gx < HS_START + hsw);
    vs_n = !(gy >= VS_START && gy < VS_START + VS);
    gen_vs_fall = bus.i_vsync & !vs_n;
    gen_hs_rise = !bus.i_hsync & hs_n;
    @(negedge clk);
    bus.i_hsync   = hs_n;
    bus.i_vsync   = vs_n;
    bus.i_pix_stb = 1'b1;
    @(negedge clk);
    bus.i_pix_stb = 1'b0;
    err_now = bus.o_err;
    sample_after();
    @(negedge clk);
    sample_after();
    @(negedge clk);
    sample_after();
  endtask

  task automatic run_to_vs_fall(input string tag);
    int n;
    n = 0;
    do begin
      do_strobe();
      n++;
    end while (!gen_vs_fall && n < 4 * HT * VT);
    if (!gen_vs_fall) begin
      checks++;
      failures++;
      $error("FAIL %s: vsync fall not reached within budget", tag);
    end
  endtask

  task automatic run_until_pos(input int x, input int y);
    int n;
    n = 0;
    do begin
      do_strobe();
      n++;
    end while (!(gx == x && (y < 0 || gy == y)) && n < 4 * HT * VT);
    if (!(gx == x && (y < 0 || gy == y))) begin
      checks++;
      failures++;
      $error("FAIL pos_wait: position x=%0d y=%0d not reached", x, y);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.i_pix_stb = 1'b0;
    bus.i_hsync   = 1'b1;
    bus.i_vsync   = 1'b1;
    gx = 0; gy = 0; htot = HT; hsw = HS; vtot = VT;
    err_sight = 0; lock_seen = 1'b0; err_now = 1'b0;
    gen_vs_fall = 1'b0; gen_hs_rise = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_x", bus.o_x, 0);
    check("rst_y", bus.o_y, 0);
    check("rst_active", bus.o_active, 0);
    check("rst_locked", bus.o_locked, 0);
    check("rst_err", bus.o_err, 0);
    check("rst_frame_cnt", bus.o_frame_cnt, 0);
    rst_n = 1'b1;

    // Acquire: lock on the third vsync fall
    run_to_vs_fall("acq1");
    check("acq_vs1_locked", bus.o_locked, 0);
    run_to_vs_fall("acq2");
    check("acq_vs2_locked", bus.o_locked, 0);
    run_to_vs_fall("acq3");
    check("acq_vs3_locked", bus.o_locked, 1);
    check("acq_frame_cnt", bus.o_frame_cnt, 0);
    check("acq_no_err", err_sight, 0);

    // Locked tracking over three frames
    for (int f = 1; f <= 3; f++) begin
      int mism, act, n;
      mism = 0; act = 0; n = 0;
      do begin
        do_strobe();
        n++;
        if (bus.o_x !== 16'(gx) || bus.o_y !== 16'(gy)) mism++;
        if (bus.o_active !== ((gx < HA) && (gy < VA))) mism++;
        if (bus.o_active === 1'b1) act++;
      end while (!gen_vs_fall && n < 4 * HT * VT);
      check($sformatf("track_mismatch_f%0d", f), mism, 0);
      check($sformatf("active_strobes_f%0d", f), act, HA * VA);
      check($sformatf("frame_cnt_f%0d", f), bus.o_frame_cnt, f);
    end

    // One line shortened by a strobe
    run_until_pos(0, -1);
    htot = HT - 1;
    e0 = err_sight;
    run_until_pos(0, -1);
    htot = HT;
    repeat (2 * HT) do_strobe();
    check("short_line_err_pulses", err_sight - e0, 1);
    check("short_line_locked", bus.o_locked, 0);
    check("short_line_frame_held", bus.o_frame_cnt, 3);
    run_to_vs_fall("relock1");
    check("relock_vs1_locked", bus.o_locked, 0);
    run_to_vs_fall("relock2");
    check("relock_vs2_locked", bus.o_locked, 0);
    run_to_vs_fall("relock3");
    check("relock_vs3_locked", bus.o_locked, 1);
    check("relock_frame_held", bus.o_frame_cnt, 3);
    run_to_vs_fall("relock4");
    check("relock_frame_inc", bus.o_frame_cnt, 4);

    // Frames one line short
    vtot = VT - 1;
    e0 = err_sight;
    run_to_vs_fall("short_frame");
    check("short_frame_err_at_vs", err_now, 1);
    check("short_frame_err_pulses", err_sight - e0, 1);
    check("short_frame_locked", bus.o_locked, 0);
    check("short_frame_frame_held", bus.o_frame_cnt, 4);
    lock_seen = 1'b0;
    e0 = err_sight;
    for (int k = 0; k < 4; k++) run_to_vs_fall("short_frame_loop");
    check("check_state_err_pulses", err_sight - e0, 2);
    check("check_state_never_locked", lock_seen, 0);
    vtot = VT;
    run_to_vs_fall("recover1");
    run_to_vs_fall("recover2");
    run_to_vs_fall("recover3");
    check("recover_locked", bus.o_locked, 1);

    // Asynchronous reset mid-line in the active area
    run_until_pos(8, 2);
    check("pre_rst_x", bus.o_x, 8);
    check("pre_rst_y", bus.o_y, 2);
    check("pre_rst_active", bus.o_active, 1);
    check("pre_rst_frame_cnt", bus.o_frame_cnt, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", bus.o_x, 0);
    check("async_rst_y", bus.o_y, 0);
    check("async_rst_active", bus.o_active, 0);
    check("async_rst_locked", bus.o_locked, 0);
    check("async_rst_err", bus.o_err, 0);
    check("async_rst_frame_cnt", bus.o_frame_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e0 = err_sight;
    run_to_vs_fall("post_rst1");
    check("post_rst_vs1_locked", bus.o_locked, 0);
    run_to_vs_fall("post_rst2");
    check("post_rst_vs2_locked", bus.o_locked, 0);
    run_to_vs_fall("post_rst3");
    check("post_rst_vs3_locked", bus.o_locked, 1);
    check("post_rst_frame_cnt", bus.o_frame_cnt, 0);
    check("post_rst_no_err", err_sight - e0, 0);

    // Hsync one strobe narrow, line period unchanged
    run_until_pos(0, -1);
    hsw = HS - 1;
    e0 = err_sight;
    for (int k = 0; k < HT; k++) begin
      do_strobe();
      if (gen_hs_rise) check("width_err_at_rise", err_now, W_EN);
    end
    hsw = HS;
    repeat (2) do_strobe();
    check("width_err_pulses", err_sight - e0, W_EN ? 1 : 0);
    check("width_locked", bus.o_locked, !W_EN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
